// File: rtl/ov7670_pkg.sv
// Shared types and marker constants for the OV7670 register-config sequencer.
package ov7670_pkg;

  localparam logic [15:0] DELAY_CODE = 16'hFFF0;
  localparam logic [15:0] END_CODE   = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    SEND,
    WAIT_RSP,
    DELAY,
    ADVANCE,
    DONE
  } state_t;

  // One ROM entry: sensor register address in the high byte, value in the low byte.
  typedef struct packed {
    logic [7:0] reg_a;
    logic [7:0] val;
  } cfg_word_t;

  function automatic cfg_word_t to_cfg(input logic [15:0] w);
    return cfg_word_t'(w);
  endfunction

endpackage

// File: rtl/ov7670_config_seq_if.sv
// Command/response channel between the config sequencer and the SCCB master.
interface ov7670_config_seq_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_reg;
  logic [7:0] cmd_val;
  logic       rsp_valid;
  logic       rsp_nack;

  modport master (
    output cmd_valid, cmd_reg, cmd_val,
    input  cmd_ready, rsp_valid, rsp_nack
  );

  modport slave (
    input  cmd_valid, cmd_reg, cmd_val,
    output cmd_ready, rsp_valid, rsp_nack
  );

endinterface

// File: rtl/ov7670_config_seq.sv
// Walks the external config ROM and issues one SCCB write per {reg,val} entry.
// Marker words insert a fixed delay or end the run; NACKed writes are re-sent
// a bounded number of times before the run aborts with error.
module ov7670_config_seq #(
  parameter int          ADDR_W       = 8,
  parameter int          ROM_LAT      = 1,
  parameter logic [15:0] DELAY_CODE   = 16'hFFF0,
  parameter logic [15:0] END_CODE     = 16'hFFFF,
  parameter int          DELAY_CYCLES = 250000,
  parameter int          MAX_RETRY    = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [15:0]              rom_data,
  ov7670_config_seq_if.master      sccb,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [ADDR_W-1:0]        entries_sent
);
  import ov7670_pkg::*;

  localparam int DW = $clog2(DELAY_CYCLES + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  // FETCH runs ROM_LAT cycles so DECODE sees the word for the current address.
  localparam logic [1:0]    LAT_INIT = 2'(ROM_LAT - 1);
  // Counting DELAY_CYCLES-1 down to 0 inclusive gives DELAY_CYCLES cycles in DELAY.
  localparam logic [DW-1:0] DLY_INIT = DW'(DELAY_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [1:0]        lat_q,   lat_d;
  logic [DW-1:0]     dly_q,   dly_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic              vld_q,   vld_d;
  cfg_word_t         word_q,  word_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;
  logic              err_q,   err_d;
  logic [ADDR_W-1:0] ent_q,   ent_d;

  // State and datapath registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      lat_q   <= '0;
      dly_q   <= '0;
      retry_q <= '0;
      vld_q   <= 1'b0;
      word_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ent_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lat_q   <= lat_d;
      dly_q   <= dly_d;
      retry_q <= retry_d;
      vld_q   <= vld_d;
      word_q  <= word_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ent_q   <= ent_d;
    end
  end

  // Next-state and next-register values; everything holds unless a state moves it.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lat_d   = lat_q;
    dly_d   = dly_q;
    retry_d = retry_q;
    vld_d   = vld_q;
    word_d  = word_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    ent_d   = ent_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          ent_d   = '0;
          busy_d  = 1'b1;
          lat_d   = LAT_INIT;
          state_d = FETCH;
        end
      end

      FETCH: begin
        if (lat_q == 2'd0) state_d = DECODE;
        else               lat_d   = lat_q - 1'b1;
      end

      DECODE: begin
        if (rom_data == END_CODE) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end else if (rom_data == DELAY_CODE) begin
          dly_d   = DLY_INIT;
          state_d = DELAY;
        end else begin
          word_d  = to_cfg(rom_data);
          retry_d = '0;
          vld_d   = 1'b1;
          state_d = SEND;
        end
      end

      // Payload is a register, so it stays put for as long as the master stalls.
      SEND: begin
        if (sccb.cmd_ready) begin
          vld_d   = 1'b0;
          state_d = WAIT_RSP;
        end
      end

      WAIT_RSP: begin
        if (sccb.rsp_valid) begin
          if (!sccb.rsp_nack) begin
            if (~&ent_q) ent_d = ent_q + 1'b1;
            state_d = ADVANCE;
          end else if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 1'b1;
            vld_d   = 1'b1;
            state_d = SEND;
          end else begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
          end
        end
      end

      DELAY: begin
        if (dly_q == '0) state_d = ADVANCE;
        else             dly_d   = dly_q - 1'b1;
      end

      // Running off the end of the address space without END_CODE is a table bug.
      ADVANCE: begin
        if (&addr_q) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          lat_d   = LAT_INIT;
          state_d = FETCH;
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rom_addr       = addr_q;
  assign sccb.cmd_valid = vld_q;
  assign sccb.cmd_reg   = word_q.reg_a;
  assign sccb.cmd_val   = word_q.val;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = err_q;
  assign entries_sent   = ent_q;

endmodule

// File: tb/tb_ov7670_config_seq.sv
// Directed bench: two sequencer instances (short-ROM/low-latency and
// 3-bit-address/3-cycle-ROM) with ROM and SCCB responder models.
module tb_ov7670_config_seq;
  import ov7670_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;

  // ---------------- instance A: ADDR_W=8, ROM_LAT=1, DELAY=8, MAX_RETRY=2
  logic        rst_a, start_a, busy_a, done_a, err_a;
  logic [7:0]  addr_a, ent_a;
  logic [15:0] data_a;
  logic [15:0] rom_a [256];
  ov7670_config_seq_if ifa();

  ov7670_config_seq #(.ADDR_W(8), .ROM_LAT(1), .DELAY_CYCLES(8), .MAX_RETRY(2)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .rom_addr(addr_a), .rom_data(data_a),
    .sccb(ifa), .busy(busy_a), .done(done_a), .error(err_a), .entries_sent(ent_a));

  always @(posedge clk) data_a <= rom_a[addr_a];

  logic [15:0] wr_a[$];
  int nacks_sent = 0;
  int nack_goal  = 0;
  bit pend_a = 1'b0;
  int wt_a = 0;
  bit xfer_a;
  // SCCB master model: logs each transfer, answers two cycles later.
  always @(posedge clk) begin
    xfer_a = ifa.cmd_valid && ifa.cmd_ready && !rst_a;
    if (xfer_a) wr_a.push_back({ifa.cmd_reg, ifa.cmd_val});
    #1;
    ifa.rsp_valid = 1'b0;
    ifa.rsp_nack  = 1'b0;
    if (rst_a) pend_a = 1'b0;
    else if (xfer_a) begin pend_a = 1'b1; wt_a = 2; end
    else if (pend_a) begin
      wt_a--;
      if (wt_a == 0) begin
        pend_a = 1'b0;
        ifa.rsp_valid = 1'b1;
        if (nacks_sent < nack_goal) begin ifa.rsp_nack = 1'b1; nacks_sent++; end
      end
    end
  end

  int dly_cyc_a = 0, run_a = 0, fbad_a = 0;
  // Observes the FSM: cycles spent in DELAY, FETCH run length before each DECODE.
  always @(posedge clk) begin
    if (dut_a.state_q == DELAY) dly_cyc_a++;
    if (dut_a.state_q == FETCH) run_a++;
    else if (dut_a.state_q == DECODE) begin
      if (run_a != 1) fbad_a++;
      run_a = 0;
    end else run_a = 0;
  end

  // ---------------- instance B: ADDR_W=3, ROM_LAT=3, DELAY=4, MAX_RETRY=0
  logic        rst_b, start_b, busy_b, done_b, err_b;
  logic [2:0]  addr_b, ent_b;
  logic [15:0] data_b, p1_b, p2_b;
  logic [15:0] rom_b [8];
  ov7670_config_seq_if ifb();

  ov7670_config_seq #(.ADDR_W(3), .ROM_LAT(3), .DELAY_CYCLES(4), .MAX_RETRY(0)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .rom_addr(addr_b), .rom_data(data_b),
    .sccb(ifb), .busy(busy_b), .done(done_b), .error(err_b), .entries_sent(ent_b));

  always @(posedge clk) begin
    p1_b   <= rom_b[addr_b];
    p2_b   <= p1_b;
    data_b <= p2_b;
  end

  logic [15:0] wr_b[$];
  bit pend_b = 1'b0;
  bit xfer_b;
  // Always-ACK responder, answers one cycle after the transfer.
  always @(posedge clk) begin
    xfer_b = ifb.cmd_valid && ifb.cmd_ready && !rst_b;
    if (xfer_b) wr_b.push_back({ifb.cmd_reg, ifb.cmd_val});
    #1;
    ifb.rsp_valid = 1'b0;
    ifb.rsp_nack  = 1'b0;
    if (rst_b) pend_b = 1'b0;
    else if (xfer_b) pend_b = 1'b1;
    else if (pend_b) begin pend_b = 1'b0; ifb.rsp_valid = 1'b1; end
  end

  int run_b = 0, fbad_b = 0, dec_b = 0;
  always @(posedge clk) begin
    if (dut_b.state_q == FETCH) run_b++;
    else if (dut_b.state_q == DECODE) begin
      dec_b++;
      if (run_b != 3) fbad_b++;
      run_b = 0;
    end else run_b = 0;
  end

  // ---------------- stimulus helpers
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_a();
    start_a = 1'b1; tick(); start_a = 1'b0;
  endtask

  task automatic pulse_b();
    start_b = 1'b1; tick(); start_b = 1'b0;
  endtask

  task automatic wait_a(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (!busy_a) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_b(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (!busy_b) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_delay_a(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (dut_a.state_q == DELAY) begin ok = 1'b1; break; end
    end
  endtask

  function automatic logic [15:0] wa(input int i);
    return (i < wr_a.size()) ? wr_a[i] : 16'hxxxx;
  endfunction

  function automatic logic [15:0] wb(input int i);
    return (i < wr_b.size()) ? wr_b[i] : 16'hxxxx;
  endfunction

  // ---------------- tests
  task automatic test_reset();
    start_a = 1'b1;
    repeat (3) tick();
    start_a = 1'b0;
    nvec++; if ({busy_a, done_a, err_a} !== 3'b000) begin nmis++; $display("FAIL reset_flags_a: got %b want 000", {busy_a, done_a, err_a}); end
    nvec++; if (addr_a !== 8'd0 || ent_a !== 8'd0) begin nmis++; $display("FAIL reset_cnt_a: addr %h ent %h want 0 0", addr_a, ent_a); end
    nvec++; if ({ifa.cmd_valid, ifa.cmd_reg, ifa.cmd_val} !== 17'd0) begin nmis++; $display("FAIL reset_cmd_a: got %h want 0", {ifa.cmd_valid, ifa.cmd_reg, ifa.cmd_val}); end
    nvec++; if ({busy_b, done_b, err_b, addr_b, ent_b} !== 9'd0) begin nmis++; $display("FAIL reset_b: got %h want 0", {busy_b, done_b, err_b, addr_b, ent_b}); end
    rst_a = 1'b0; rst_b = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int n0, d0, f0; bit ok;
    rom_a[0] = 16'h1280; rom_a[1] = 16'hFFF0; rom_a[2] = 16'h1204; rom_a[3] = 16'hFFFF;
    tick();
    n0 = wr_a.size(); d0 = dly_cyc_a; f0 = fbad_a;
    pulse_a();
    nvec++; if (busy_a !== 1'b1) begin nmis++; $display("FAIL basic_busy: got %b want 1", busy_a); end
    wait_a(200, ok);
    nvec++; if (!ok) begin nmis++; $display("FAIL basic_timeout: busy stuck, want finish within 200 cycles"); end
    nvec++; if (wr_a.size() - n0 != 2) begin nmis++; $display("FAIL basic_nwr: got %0d want 2", wr_a.size() - n0); end
    nvec++; if (wa(n0) !== 16'h1280 || wa(n0 + 1) !== 16'h1204) begin nmis++; $display("FAIL basic_payload: got %h %h want 1280 1204", wa(n0), wa(n0 + 1)); end
    nvec++; if (dly_cyc_a - d0 != 8) begin nmis++; $display("FAIL basic_delay: got %0d cycles want 8", dly_cyc_a - d0); end
    nvec++; if ({done_a, err_a, busy_a} !== 3'b100) begin nmis++; $display("FAIL basic_status: got %b want 100", {done_a, err_a, busy_a}); end
    nvec++; if (ent_a !== 8'd2) begin nmis++; $display("FAIL basic_entries: got %0d want 2", ent_a); end
    nvec++; if (fbad_a != f0) begin nmis++; $display("FAIL basic_fetch_lat: got %0d bad fetches want 0", fbad_a - f0); end
  endtask

  task automatic test_backpressure();
    int n0, bad; bit ok;
    rom_a[0] = 16'h1234; rom_a[1] = 16'hFFFF;
    tick();
    ifa.cmd_ready = 1'b0;
    n0 = wr_a.size();
    pulse_a();
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ifa.cmd_valid) begin ok = 1'b1; break; end
      tick();
    end
    nvec++; if (!ok) begin nmis++; $display("FAIL bp_valid: cmd_valid never rose, want 1 within 20 cycles"); end
    bad = 0;
    repeat (5) begin
      tick();
      if (ifa.cmd_valid !== 1'b1 || {ifa.cmd_reg, ifa.cmd_val} !== 16'h1234) bad++;
    end
    nvec++; if (bad != 0) begin nmis++; $display("FAIL bp_stable: got %0d unstable cycles want 0", bad); end
    nvec++; if (wr_a.size() != n0) begin nmis++; $display("FAIL bp_no_xfer: got %0d transfers want 0", wr_a.size() - n0); end
    ifa.cmd_ready = 1'b1;
    wait_a(100, ok);
    nvec++; if (!ok || wr_a.size() - n0 != 1 || wa(n0) !== 16'h1234) begin nmis++; $display("FAIL bp_single: got %0d writes first %h want 1 write 1234", wr_a.size() - n0, wa(n0)); end
    nvec++; if ({done_a, err_a} !== 2'b10 || ent_a !== 8'd1) begin nmis++; $display("FAIL bp_status: got done/err %b ent %0d want 10 1", {done_a, err_a}, ent_a); end
  endtask

  task automatic test_retry();
    int n0; bit ok;
    rom_a[0] = 16'h1180; rom_a[1] = 16'hFFFF;
    tick();
    n0 = wr_a.size();
    nack_goal = nacks_sent + 2;
    pulse_a();
    wait_a(200, ok);
    nvec++; if (!ok || wr_a.size() - n0 != 3) begin nmis++; $display("FAIL retry_nwr: got %0d want 3", wr_a.size() - n0); end
    nvec++; if (wa(n0) !== 16'h1180 || wa(n0 + 1) !== 16'h1180 || wa(n0 + 2) !== 16'h1180) begin nmis++; $display("FAIL retry_payload: got %h %h %h want 1180 x3", wa(n0), wa(n0 + 1), wa(n0 + 2)); end
    nvec++; if ({done_a, err_a, busy_a} !== 3'b100 || ent_a !== 8'd1) begin nmis++; $display("FAIL retry_status: got %b ent %0d want 100 1", {done_a, err_a, busy_a}, ent_a); end
  endtask

  task automatic test_retry_fail();
    int n0; bit ok;
    tick();
    n0 = wr_a.size();
    nack_goal = nacks_sent + 3;
    pulse_a();
    wait_a(200, ok);
    nvec++; if (!ok || wr_a.size() - n0 != 3) begin nmis++; $display("FAIL rfail_nwr: got %0d want 3", wr_a.size() - n0); end
    nvec++; if ({done_a, err_a, busy_a} !== 3'b010) begin nmis++; $display("FAIL rfail_status: got %b want 010", {done_a, err_a, busy_a}); end
    nvec++; if (ent_a !== 8'd0) begin nmis++; $display("FAIL rfail_entries: got %0d want 0", ent_a); end
  endtask

  task automatic test_reset_delay();
    int n0, d0; bit ok;
    rom_a[0] = 16'h1280; rom_a[1] = 16'hFFF0; rom_a[2] = 16'h1204; rom_a[3] = 16'hFFFF;
    tick();
    pulse_a();
    wait_delay_a(50, ok);
    nvec++; if (!ok || ent_a !== 8'd1) begin nmis++; $display("FAIL rstd_reach: ok %b ent %0d want 1 1", ok, ent_a); end
    rst_a = 1'b1; tick(); rst_a = 1'b0;
    nvec++; if ({busy_a, done_a, err_a, ifa.cmd_valid} !== 4'b0000 || addr_a !== 8'd0 || ent_a !== 8'd0) begin nmis++; $display("FAIL rstd_clear: flags %b addr %h ent %h want 0000 0 0", {busy_a, done_a, err_a, ifa.cmd_valid}, addr_a, ent_a); end
    nvec++; if (dut_a.dly_q !== '0 || dut_a.retry_q !== '0) begin nmis++; $display("FAIL rstd_counters: dly %0d retry %0d want 0 0", dut_a.dly_q, dut_a.retry_q); end
    tick();
    n0 = wr_a.size(); d0 = dly_cyc_a;
    pulse_a();
    wait_delay_a(50, ok);
    pulse_a();
    wait_a(200, ok);
    nvec++; if (!ok || wr_a.size() - n0 != 2 || wa(n0) !== 16'h1280 || wa(n0 + 1) !== 16'h1204) begin nmis++; $display("FAIL rstd_rerun: got %0d writes %h %h want 2 1280 1204", wr_a.size() - n0, wa(n0), wa(n0 + 1)); end
    nvec++; if (dly_cyc_a - d0 != 8 || {done_a, err_a} !== 2'b10 || ent_a !== 8'd2) begin nmis++; $display("FAIL rstd_status: dly %0d done/err %b ent %0d want 8 10 2", dly_cyc_a - d0, {done_a, err_a}, ent_a); end
  endtask

  task automatic test_overflow();
    int n0; bit ok;
    for (int i = 0; i < 8; i++) rom_b[i] = {8'h20 + 8'(i), 8'(i)};
    tick();
    n0 = wr_b.size();
    pulse_b();
    wait_b(300, ok);
    nvec++; if (!ok || wr_b.size() - n0 != 8) begin nmis++; $display("FAIL ovf_nwr: got %0d want 8", wr_b.size() - n0); end
    nvec++; if (wb(n0) !== 16'h2000 || wb(n0 + 7) !== 16'h2707) begin nmis++; $display("FAIL ovf_payload: got %h..%h want 2000..2707", wb(n0), wb(n0 + 7)); end
    nvec++; if ({done_b, err_b, busy_b} !== 3'b010) begin nmis++; $display("FAIL ovf_status: got %b want 010", {done_b, err_b, busy_b}); end
    nvec++; if (addr_b !== 3'd7) begin nmis++; $display("FAIL ovf_addr: got %0d want 7", addr_b); end
    nvec++; if (ent_b !== 3'd7) begin nmis++; $display("FAIL ovf_entries_sat: got %0d want 7", ent_b); end
  endtask

  task automatic test_rom_lat3();
    int n0, f0, c0; bit ok;
    rom_b[0] = 16'hA101; rom_b[1] = 16'hA202; rom_b[2] = 16'hA303; rom_b[3] = 16'hFFFF;
    tick();
    n0 = wr_b.size(); f0 = fbad_b; c0 = dec_b;
    pulse_b();
    wait_b(300, ok);
    nvec++; if (!ok || wr_b.size() - n0 != 3) begin nmis++; $display("FAIL lat3_nwr: got %0d want 3", wr_b.size() - n0); end
    nvec++; if (wb(n0) !== 16'hA101 || wb(n0 + 1) !== 16'hA202 || wb(n0 + 2) !== 16'hA303) begin nmis++; $display("FAIL lat3_payload: got %h %h %h want A101 A202 A303", wb(n0), wb(n0 + 1), wb(n0 + 2)); end
    nvec++; if (fbad_b != f0 || dec_b - c0 != 4) begin nmis++; $display("FAIL lat3_timing: bad %0d decodes %0d want 0 4", fbad_b - f0, dec_b - c0); end
    nvec++; if ({done_b, err_b, busy_b} !== 3'b100 || ent_b !== 3'd3) begin nmis++; $display("FAIL lat3_status: got %b ent %0d want 100 3", {done_b, err_b, busy_b}, ent_b); end
  endtask

  initial begin
    rst_a = 1'b1; start_a = 1'b0; ifa.cmd_ready = 1'b1;
    rst_b = 1'b1; start_b = 1'b0; ifb.cmd_ready = 1'b1;
    foreach (rom_a[i]) rom_a[i] = 16'h0000;
    foreach (rom_b[i]) rom_b[i] = 16'h0000;
    test_reset();
    test_basic();
    test_backpressure();
    test_retry();
    test_retry_fail();
    test_reset_delay();
    test_overflow();
    test_rom_lat3();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
